// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM for a multicycle RV32I core. Owns pc,
// the instruction register and the load-data register; the shared memory
// port carries both instruction fetches and data accesses.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [31:0] load_data,
  output logic        retire,
  output logic        halted
);

  // state    | meaning
  // S_FETCH  | request word at pc, latch instr on ack
  // S_DECODE | opcode legality check
  // S_EXEC   | compute next_pc, check alignment / funct3
  // S_MEM    | data access at word-aligned alu_result, wait for ack
  // S_WB     | register write, pc update, retire pulse
  // S_TRAP   | halted, absorbing until rst

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_load_data;
  logic [31:0] r_next_pc;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_is_op;
  logic        w_is_op_imm;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_misc;
  logic        w_is_system;
  logic        w_opcode_ok;
  logic        w_is_ls;
  logic        w_ls_f3_ok;
  logic        w_ls_misaligned;
  logic        w_writes_rd;
  logic        w_exec_trap;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus_imm;
  logic [31:0] w_next_pc;
  logic [1:0]  w_off;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];
  assign w_rd     = r_instr[11:7];

  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_branch = (w_opcode == OPC_BRANCH);
  assign w_is_jal    = (w_opcode == OPC_JAL);
  assign w_is_jalr   = (w_opcode == OPC_JALR);
  assign w_is_lui    = (w_opcode == OPC_LUI);
  assign w_is_auipc  = (w_opcode == OPC_AUIPC);
  assign w_is_misc   = (w_opcode == OPC_MISC);
  assign w_is_system = (w_opcode == OPC_SYSTEM);

  // every legal opcode has instr[1:0]==2'b11, so the opcode match covers it
  assign w_opcode_ok = w_is_op | w_is_op_imm | w_is_load | w_is_store | w_is_branch |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_misc |
                       w_is_system;

  assign w_is_ls     = w_is_load | w_is_store;
  assign w_writes_rd = w_is_op | w_is_op_imm | w_is_load | w_is_jal | w_is_jalr |
                       w_is_lui | w_is_auipc;

  // loads: LB LH LW LBU LHU; stores: SB SH SW
  assign w_ls_f3_ok = w_is_load ? ((w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11))
                                : (!w_funct3[2] && (w_funct3[1:0] != 2'b11));

  assign w_off = alu_result[1:0];
  assign w_ls_misaligned = ((w_funct3[1:0] == 2'b01) && w_off[0]) ||
                           ((w_funct3[1:0] == 2'b10) && (w_off != 2'b00));

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_plus_imm = r_pc + imm;

  // next_pc selection; only meaningful while in S_EXEC
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_is_jal) begin
      w_next_pc = w_pc_plus_imm;
    end else if (w_is_jalr) begin
      w_next_pc = {alu_result[31:1], 1'b0};
    end else if (w_is_branch && branch_taken) begin
      w_next_pc = w_pc_plus_imm;
    end
  end

  assign w_exec_trap = (w_next_pc[1:0] != 2'b00) ||
                       (w_is_ls && (!w_ls_f3_ok || w_ls_misaligned));

  // store lane enables and lane-replicated write data
  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = rs2_data;
    case (w_funct3[1:0])
      2'b00: begin
        w_store_be    = 4'b0001 << w_off;
        w_store_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        w_store_be    = 4'b0011 << w_off;
        w_store_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = rs2_data;
      end
    endcase
  end

  // load lane extraction and sign/zero extension
  always_comb begin
    w_ld_byte = mem_rdata[7:0];
    case (w_off)
      2'b00:   w_ld_byte = mem_rdata[7:0];
      2'b01:   w_ld_byte = mem_rdata[15:8];
      2'b10:   w_ld_byte = mem_rdata[23:16];
      default: w_ld_byte = mem_rdata[31:24];
    endcase
    w_ld_half = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  // next-state and memory-port outputs
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = r_pc;
    mem_be      = 4'b1111;
    mem_wdata   = 32'd0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_opcode_ok || w_is_system) begin
          w_state_nxt = S_TRAP;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_exec_trap) begin
          w_state_nxt = S_TRAP;
        end else if (w_is_ls) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = {alu_result[31:2], 2'b00};
        if (w_is_store) begin
          mem_we    = 1'b1;
          mem_be    = w_store_be;
          mem_wdata = w_store_wdata;
        end
        if (mem_ack) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        w_state_nxt = S_TRAP;
      end
      default: begin
        w_state_nxt = S_TRAP;
      end
    endcase
  end

  // state, pc, instruction, next_pc and load-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_load_data <= 32'd0;
      r_next_pc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_FETCH) && mem_ack) begin
        r_instr <= mem_rdata;
      end
      if (r_state == S_EXEC) begin
        r_next_pc <= w_next_pc;
      end
      if ((r_state == S_MEM) && mem_ack && w_is_load) begin
        r_load_data <= w_ld_ext;
      end
      if (r_state == S_WB) begin
        r_pc <= r_next_pc;
      end
    end
  end

  assign instr     = r_instr;
  assign pc        = r_pc;
  assign load_data = r_load_data;

  assign alu_a_sel = w_is_auipc | w_is_jal | w_is_branch;
  assign alu_b_sel = !(w_is_op | w_is_branch);

  assign rf_we   = (r_state == S_WB) && w_writes_rd && (w_rd != 5'd0);
  assign rf_wsel = w_is_load              ? 2'b01 :
                   (w_is_jal | w_is_jalr) ? 2'b10 :
                   w_is_lui               ? 2'b11 : 2'b00;

  assign retire = (r_state == S_WB);
  assign halted = (r_state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench. The driver runs one instruction at a
// time, predicts its memory transfers / retire / trap from ISA rules and
// queues them; the monitor compares whatever the DUT presents.
module tb_multicycle_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] imm = 32'd0, alu_result = 32'd0, rs2_data = 32'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] pc;
  logic        alu_a_sel, alu_b_sel, rf_we;
  logic [1:0]  rf_wsel;
  logic [31:0] load_data;
  logic        retire, halted;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr),
    .imm(imm), .alu_result(alu_result), .rs2_data(rs2_data),
    .branch_taken(branch_taken),
    .pc(pc), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .load_data(load_data),
    .retire(retire), .halted(halted)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk_be;
    logic [3:0]  be;
    logic        chk_wd;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic        rf_we;
    logic [1:0]  wsel;
    logic        a_sel;
    logic        b_sel;
    logic        chk_ld;
    logic [31:0] ld;
  } ret_t;

  mreq_t       exp_mem[$];
  ret_t        exp_ret[$];
  logic [31:0] exp_trap[$];

  int          n_pass = 0;
  int          n_total = 0;
  logic        mon_en = 1'b0;
  logic [31:0] m_pc = RPC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic flag_fail(input string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // monitor: compare every presented request, retire and trap with the queues
  mreq_t       mon_m;
  ret_t        mon_r;
  logic        trap_seen = 1'b0;
  logic [31:0] trap_pc = 32'd0;
  always @(negedge clk) begin
    if (rst) begin
      trap_seen = 1'b0;
    end else if (mon_en) begin
      if (mem_req) begin
        if (exp_mem.size() == 0) begin
          flag_fail("unexpected_mem_req");
        end else begin
          mon_m = exp_mem[0];
          check("mem_addr", mem_addr, mon_m.addr);
          check("mem_we", 32'(mem_we), 32'(mon_m.we));
          if (mon_m.chk_be) check("mem_be", 32'(mem_be), 32'(mon_m.be));
          if (mon_m.chk_wd) check("mem_wdata", mem_wdata, mon_m.wdata);
          if (mem_ack) void'(exp_mem.pop_front());
        end
      end
      if (retire) begin
        if (exp_ret.size() == 0) begin
          flag_fail("unexpected_retire");
        end else begin
          mon_r = exp_ret.pop_front();
          check("rf_we", 32'(rf_we), 32'(mon_r.rf_we));
          check("rf_wsel", 32'(rf_wsel), 32'(mon_r.wsel));
          check("alu_a_sel", 32'(alu_a_sel), 32'(mon_r.a_sel));
          check("alu_b_sel", 32'(alu_b_sel), 32'(mon_r.b_sel));
          if (mon_r.chk_ld) check("load_data", load_data, mon_r.ld);
        end
      end
      if (halted) begin
        if (!trap_seen) begin
          if (exp_trap.size() == 0) begin
            flag_fail("unexpected_halt");
          end else begin
            trap_pc = exp_trap.pop_front();
            check("trap_pc", pc, trap_pc);
          end
          trap_seen = 1'b1;
        end else begin
          check("trap_pc_hold", pc, trap_pc);
        end
        check("trap_mem_req", 32'(mem_req), 32'd0);
        check("trap_rf_we", 32'(rf_we), 32'd0);
      end
    end
  end

  task automatic do_reset(input logic ack_during);
    rst = 1'b1;
    mem_ack = ack_during;
    mem_rdata = 32'h0000_0000;
    exp_mem.delete();
    exp_ret.delete();
    exp_trap.delete();
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = RPC;
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_load_data", load_data, 32'd0);
    check("rst_flags", {28'd0, halted, retire, rf_we, mem_we}, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd1);
    check("rst_mem_addr", mem_addr, RPC);
  endtask

  task automatic do_xfer(input logic [31:0] data, output bit ok);
    int cnt = 0;
    ok = 1'b1;
    while (!mem_req && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!mem_req) begin
      flag_fail("xfer_timeout");
      ok = 1'b0;
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  // one instruction: predict from ISA rules, queue expectations, then drive
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] im, input logic [31:0] alu,
                           input logic [31:0] rs2, input logic bt, input logic [31:0] rdat);
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [4:0]  rd = ins[11:7];
    bit          known, trap, is_ld, is_st, ok, done;
    int          nbytes, off, cnt;
    logic [31:0] npc, v;
    mreq_t       mr;
    ret_t        rr;

    known = opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    trap  = !known || (opc == 7'h73);
    is_ld = (opc == 7'h03);
    is_st = (opc == 7'h23);
    nbytes = 1 << f3[1:0];
    off = int'(alu[1:0]);
    if (!trap && (is_ld || is_st)) begin
      if (is_ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) trap = 1'b1;
      if (is_st && f3 > 3'd2) trap = 1'b1;
      if ((int'(alu[2:0]) % nbytes) != 0) trap = 1'b1;
    end
    case (opc)
      7'h6F:   npc = m_pc + im;
      7'h67:   npc = alu & ~32'd1;
      7'h63:   npc = bt ? m_pc + im : m_pc + 32'd4;
      default: npc = m_pc + 32'd4;
    endcase
    if (!trap && (npc % 4) != 0) trap = 1'b1;

    mr.we = 1'b0; mr.addr = m_pc; mr.chk_be = 1'b1; mr.be = 4'hF;
    mr.chk_wd = 1'b0; mr.wdata = 32'd0;
    exp_mem.push_back(mr);
    if (!trap && (is_ld || is_st)) begin
      mr.we = is_st;
      mr.addr = alu - 32'(off);
      mr.chk_be = is_st;
      mr.be = 4'(((1 << nbytes) - 1) << off);
      mr.chk_wd = is_st;
      if (nbytes == 1)      mr.wdata = {24'd0, rs2[7:0]} * 32'h0101_0101;
      else if (nbytes == 2) mr.wdata = {16'd0, rs2[15:0]} * 32'h0001_0001;
      else                  mr.wdata = rs2;
      exp_mem.push_back(mr);
    end
    if (trap) begin
      exp_trap.push_back(m_pc);
    end else begin
      v = rdat >> (8 * off);
      if (nbytes == 1) begin
        v = v & 32'h0000_00FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        v = v & 32'h0000_FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      rr.rf_we = (opc inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17}) && (rd != 5'd0);
      rr.wsel = is_ld ? 2'b01 : (opc inside {7'h6F, 7'h67}) ? 2'b10 : (opc == 7'h37) ? 2'b11 : 2'b00;
      rr.a_sel = opc inside {7'h17, 7'h6F, 7'h63};
      rr.b_sel = !(opc inside {7'h33, 7'h63});
      rr.chk_ld = is_ld;
      rr.ld = v;
      exp_ret.push_back(rr);
    end

    imm = im; alu_result = alu; rs2_data = rs2; branch_taken = bt;
    do_xfer(ins, ok);
    if (ok && !trap && (is_ld || is_st)) do_xfer(rdat, ok);
    if (!ok) begin
      do_reset(1'b0);
      return;
    end
    done = 1'b0;
    cnt = 0;
    while (!done && cnt < 30) begin
      @(negedge clk);
      cnt++;
      if (trap ? halted : retire) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) begin
      flag_fail(trap ? "halt_timeout" : "retire_timeout");
      do_reset(1'b0);
    end else if (trap) begin
      mem_ack = 1'b1;
      repeat (4) begin
        mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      do_reset(1'b0);
    end else begin
      m_pc = npc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [6:0]  gen_opc [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [31:0] ins, im, alu;
    logic [6:0]  opc;
    int          r, nb;

    mon_en = 1'b1;
    do_reset(1'b0);

    // directed: ADDI, jump to 0x40, BEQ taken / not taken, LB, SH, misaligned LW
    run_instr(32'h0050_0093, 32'd5, 32'd5, 32'd0, 1'b0, 32'd0);
    run_instr(32'h0000_00EF, 32'h3C, 32'd0, 32'd0, 1'b0, 32'd0);
    run_instr(32'h0000_0063, 32'hFFFF_FFF8, 32'd0, 32'd0, 1'b1, 32'd0);
    run_instr(32'h0000_006F, 32'h8, 32'd0, 32'd0, 1'b0, 32'd0);
    run_instr(32'h0000_0063, 32'hFFFF_FFF8, 32'd0, 32'd0, 1'b0, 32'd0);
    check("pc_after_beq", pc, 32'h44);
    run_instr(32'h0000_0283, 32'd0, 32'h103, 32'd0, 1'b0, 32'h8012_3456);
    run_instr(32'h0000_1023, 32'd0, 32'h202, 32'h1234_ABCD, 1'b0, 32'd0);
    run_instr(32'h0000_2283, 32'd0, 32'h102, 32'd0, 1'b0, 32'd0);
    run_instr(32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    // fetch held without ack, then reset with an ack landing on the reset edge
    exp_mem.push_back('{we: 1'b0, addr: RPC, chk_be: 1'b1, be: 4'hF, chk_wd: 1'b0, wdata: 32'd0});
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset(1'b1);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 39);
      if (r == 39) begin
        opc = 7'(($urandom));
        while (opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F})
          opc = 7'(($urandom));
      end else if (r == 38) begin
        opc = 7'h73;
      end else begin
        opc = gen_opc[r % 10];
      end
      ins = $urandom;
      ins[6:0] = opc;
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      if (opc == 7'h03 && $urandom_range(0, 11) != 0) ins[14:12] = ld_f3[$urandom_range(0, 4)];
      if (opc == 7'h23 && $urandom_range(0, 11) != 0) ins[14:12] = 3'($urandom_range(0, 2));
      im = $urandom;
      im[1:0] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      alu = $urandom;
      if ((opc == 7'h03 || opc == 7'h23) && $urandom_range(0, 7) != 0) begin
        nb = 1 << ins[13:12];
        if (nb >= 2) alu[0] = 1'b0;
        if (nb >= 4) alu[1] = 1'b0;
      end
      if (opc == 7'h67 && $urandom_range(0, 9) != 0) alu[1] = 1'b0;
      run_instr(ins, im, alu, $urandom, 1'($urandom), $urandom);
    end

    mon_en = 1'b0;
    check("queues_drained", 32'(exp_mem.size() + exp_ret.size() + exp_trap.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32, mem_be output 4: the single shared memory request port.
REQ-005 SHALL have ports mem_ack input 1 (transfer completes in the cycle it is high with mem_req) and mem_rdata input 32 (valid with mem_ack).
REQ-006 SHALL have port instr output 32: the latched instruction register, driven to the immediate generator and decoder.
REQ-007 SHALL have ports imm input 32, alu_result input 32, rs2_data input 32, branch_taken input 1: datapath results for the current instr.
REQ-008 SHALL have ports pc output 32, alu_a_sel output 1 (0 rs1, 1 pc), alu_b_sel output 1 (0 rs2, 1 imm).
REQ-009 SHALL have ports rf_we output 1, rf_wsel output 2 (00 ALU, 01 load data, 10 pc+4, 11 imm), load_data output 32.
REQ-010 SHALL have ports retire output 1 (one-cycle pulse per completed instruction) and halted output 1 (sticky trap flag).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP; one state per cycle unless waiting on mem_ack.
REQ-012 FETCH SHALL drive mem_req=1, mem_we=0, mem_be=4'b1111, mem_addr=pc; hold all of these stable until mem_ack.
REQ-013 On mem_ack in FETCH SHALL latch instr<=mem_rdata and go to DECODE; no ack means stay in FETCH.
REQ-014 DECODE SHALL check instr[6:0] against the RV32I opcodes (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM, SYSTEM) and go to TRAP on any other value or on instr[1:0]!=2'b11.
REQ-015 SYSTEM (ECALL/EBREAK) SHALL go to TRAP; MISC-MEM (FENCE) SHALL execute as a NOP.
REQ-016 alu_a_sel SHALL be 1 for AUIPC/JAL/BRANCH; alu_b_sel SHALL be 1 for all types except OP and BRANCH; both SHALL be valid from DECODE through WB.
REQ-017 EXEC SHALL go to MEM for LOAD/STORE and to WB otherwise.
REQ-018 EXEC for LOAD/STORE SHALL go to TRAP instead if alu_result is misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-019 EXEC SHALL compute next_pc: JAL pc+imm; JALR {alu_result[31:1],1'b0}; BRANCH pc+imm if branch_taken, else pc+4; all others pc+4.
REQ-020 EXEC SHALL go to TRAP if next_pc[1:0]!=0; pc SHALL NOT update.
REQ-021 MEM SHALL drive mem_req=1, mem_addr={alu_result[31:2],2'b00}, mem_we=1 for STORE; hold all stable until mem_ack.
REQ-022 STORE mem_be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. mem_wdata = rs2_data replicated into byte/halfword lanes.
REQ-023 LOAD SHALL capture load_data on mem_ack from the addressed lane: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word.
REQ-024 A LOAD/STORE funct3 not defined by RV32I SHALL go to TRAP from EXEC.
REQ-025 WB SHALL pulse rf_we for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC only when instr[11:7]!=0.
REQ-026 WB rf_wsel: LOAD 01, JAL/JALR 10, LUI 11, else 00.
REQ-027 WB SHALL load pc<=next_pc, pulse retire, go to FETCH.
REQ-028 Latency with same-cycle mem_ack: 4 cycles for non-memory instructions, 5 for LOAD/STORE; each ack wait cycle adds one.
REQ-029 mem_req SHALL be 0 in DECODE, EXEC, WB, TRAP; a mem_ack outside FETCH/MEM SHALL be ignored.
REQ-030 TRAP SHALL set halted=1, hold pc at the faulting instruction, drive mem_req=0 and rf_we=0, and remain until rst.

Reset
REQ-031 On rst high at a clock edge SHALL set state=FETCH, pc=RESET_PC, instr=32'h0000_0013, load_data=0, next_pc=RESET_PC, halted=0; retire, rf_we, mem_we SHALL be 0.
REQ-032 rst SHALL override any in-flight transfer; an ack coinciding with rst SHALL be discarded; mem_req=1 with mem_addr=RESET_PC SHALL follow in the first post-reset cycle.

Verification
REQ-033 ADDI x1,x0,5 at 0x0, ack same cycle -> rf_we pulse in cycle 4 with rf_wsel=00, retire=1, pc=0x4 after.
REQ-034 LB from 0x103 with rdata 0x80xxxxxx -> mem_addr=0x100, load_data=0xFFFFFF80, rf_wsel=01, retire in cycle 5.
REQ-035 SH rs2_data=0x1234ABCD at 0x202 -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, no rf_we.
REQ-036 BEQ imm=-8 at pc=0x40: branch_taken=1 -> pc=0x38; branch_taken=0 -> pc=0x44.
REQ-037 LW at 0x102 or instr 0x00000000 -> TRAP, halted=1, mem_req stays 0, pc unchanged until rst.
REQ-038 Fetch held 3 cycles without ack, then rst -> mem_addr stable during wait; next cycle pc=RESET_PC, mem_req=1.
